// File: rtl/ti_cart_loader.sv
// Download sequencer for the 16-bit cartridge RAM: packs HPS bytes into big-endian words,
// then holds the console in reset for a settle period before handing the RAM port to the CPU.
module ti_cart_loader #(
  parameter int unsigned AW        = 17,
  parameter int unsigned POST_HOLD = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [AW-1:0] cpu_a,
  input  logic          cpu_we_n,
  input  logic          cpu_ce_n,
  input  logic [1:0]    cpu_be_n,
  input  logic [15:0]   cpu_d_o,
  output logic [15:0]   cpu_d_i,
  output logic [AW-1:0] ram_a,
  output logic          ram_we,
  output logic [1:0]    ram_be,
  output logic [15:0]   ram_d,
  input  logic [15:0]   ram_q,
  output logic          hold_reset,
  output logic          rom_mask,
  output logic          load_err
);

  typedef enum logic [2:0] {StInit, StLoad, StFlush, StPost, StRun} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rom_mask_q, rom_mask_d;
  logic          load_err_q, load_err_d;

  // High byte waiting for its low partner
  logic          pend_vld_q, pend_vld_d;
  logic [AW-1:0] pend_a_q, pend_a_d;
  logic [7:0]    pend_d_q, pend_d_d;

  // Odd byte deferred one cycle behind a mismatched pending flush
  logic          odd_vld_q, odd_vld_d;
  logic [AW-1:0] odd_a_q, odd_a_d;
  logic [7:0]    odd_d_q, odd_d_d;

  logic          ld_we_q, ld_we_d;
  logic [1:0]    ld_be_q, ld_be_d;
  logic [AW-1:0] ld_a_q, ld_a_d;
  logic [15:0]   ld_d_q, ld_d_d;

  logic          byte_acc;
  logic          in_range;
  logic [AW-1:0] base_off;
  logic [AW-1:0] word_a;
  logic          run;
  logic          unused_idx;

  assign unused_idx = ^ioctl_index[7:2];
  assign byte_acc   = ioctl_wr & ioctl_download;
  assign in_range   = (ioctl_addr[24:18] == 7'd0);

  always_comb begin
    base_off = '0;
    unique case (ioctl_index[1:0])
      2'd2:    base_off = AW'(32'h0000_1000);
      2'd3:    base_off = AW'(32'h0000_B000);
      default: base_off = '0;
    endcase
  end

  assign word_a = ioctl_addr[AW:1] + base_off;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_mask_d = rom_mask_q;
    load_err_d = load_err_q;
    pend_vld_d = pend_vld_q;
    pend_a_d   = pend_a_q;
    pend_d_d   = pend_d_q;
    odd_vld_d  = odd_vld_q;
    odd_a_d    = odd_a_q;
    odd_d_d    = odd_d_q;
    ld_we_d    = 1'b0;
    ld_be_d    = 2'b00;
    ld_a_d     = ld_a_q;
    ld_d_d     = ld_d_q;

    // Byte packing datapath
    if (odd_vld_q) begin
      ld_we_d   = 1'b1;
      ld_be_d   = 2'b01;
      ld_a_d    = odd_a_q;
      ld_d_d    = {8'h00, odd_d_q};
      odd_vld_d = 1'b0;
    end else if (byte_acc) begin
      if (!in_range) begin
        load_err_d = 1'b1;
      end else if (!ioctl_addr[0]) begin
        if (pend_vld_q) begin
          ld_we_d = 1'b1;
          ld_be_d = 2'b10;
          ld_a_d  = pend_a_q;
          ld_d_d  = {pend_d_q, 8'h00};
        end
        pend_vld_d = 1'b1;
        pend_a_d   = word_a;
        pend_d_d   = ioctl_dout;
      end else if (!pend_vld_q) begin
        ld_we_d = 1'b1;
        ld_be_d = 2'b01;
        ld_a_d  = word_a;
        ld_d_d  = {8'h00, ioctl_dout};
      end else if (pend_a_q == word_a) begin
        ld_we_d    = 1'b1;
        ld_be_d    = 2'b11;
        ld_a_d     = word_a;
        ld_d_d     = {pend_d_q, ioctl_dout};
        pend_vld_d = 1'b0;
      end else begin
        ld_we_d    = 1'b1;
        ld_be_d    = 2'b10;
        ld_a_d     = pend_a_q;
        ld_d_d     = {pend_d_q, 8'h00};
        pend_vld_d = 1'b0;
        odd_vld_d  = 1'b1;
        odd_a_d    = word_a;
        odd_d_d    = ioctl_dout;
      end
    end else if ((state_q == StFlush) && pend_vld_q) begin
      ld_we_d    = 1'b1;
      ld_be_d    = 2'b10;
      ld_a_d     = pend_a_q;
      ld_d_d     = {pend_d_q, 8'h00};
      pend_vld_d = 1'b0;
    end

    unique case (state_q)
      StInit: begin
        if (ioctl_download) state_d = StLoad;
      end
      StLoad: begin
        // With nothing pending the flush step is skipped entirely
        if (!ioctl_download) state_d = pend_vld_q ? StFlush : StPost;
      end
      StFlush: begin
        state_d = ioctl_download ? StLoad : StPost;
      end
      StPost: begin
        if (ioctl_download) begin
          state_d = StLoad;
        end else if (cnt_q == 8'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StRun: begin
        if (ioctl_download) state_d = StLoad;
      end
      default: state_d = StInit;
    endcase

    if ((state_d == StLoad) && (state_q != StLoad)) rom_mask_d = ~ioctl_index[0];
    if ((state_d == StPost) && (state_q != StPost)) cnt_d = 8'(POST_HOLD - 1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      rom_mask_q <= 1'b0;
      load_err_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_a_q   <= '0;
      pend_d_q   <= '0;
      odd_vld_q  <= 1'b0;
      odd_a_q    <= '0;
      odd_d_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_be_q    <= 2'b00;
      ld_a_q     <= '0;
      ld_d_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_mask_q <= rom_mask_d;
      load_err_q <= load_err_d;
      pend_vld_q <= pend_vld_d;
      pend_a_q   <= pend_a_d;
      pend_d_q   <= pend_d_d;
      odd_vld_q  <= odd_vld_d;
      odd_a_q    <= odd_a_d;
      odd_d_q    <= odd_d_d;
      ld_we_q    <= ld_we_d;
      ld_be_q    <= ld_be_d;
      ld_a_q     <= ld_a_d;
      ld_d_q     <= ld_d_d;
    end
  end

  // CPU owns the RAM port only in RUN; elsewhere its strobes are ignored
  assign run        = (state_q == StRun);
  assign ram_a      = run ? cpu_a : ld_a_q;
  assign ram_d      = run ? cpu_d_o : ld_d_q;
  assign ram_be     = run ? ~cpu_be_n : ld_be_q;
  assign ram_we     = run ? ~(cpu_we_n | cpu_ce_n) : ld_we_q;
  assign cpu_d_i    = ram_q;
  assign hold_reset = ~run;
  assign rom_mask   = rom_mask_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_ti_cart_loader.sv
// Directed bench for ti_cart_loader: byte packing, offsets, range drops, flush,
// post-load hold timing, CPU pass-through and reset behaviour.
module tb_ti_cart_loader;
  localparam int unsigned AW = 17;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [AW-1:0] cpu_a;
  logic          cpu_we_n;
  logic          cpu_ce_n;
  logic [1:0]    cpu_be_n;
  logic [15:0]   cpu_d_o;
  logic [15:0]   cpu_d_i;
  logic [AW-1:0] ram_a;
  logic          ram_we;
  logic [1:0]    ram_be;
  logic [15:0]   ram_d;
  logic [15:0]   ram_q;
  logic          hold_reset;
  logic          rom_mask;
  logic          load_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log sampled on the falling edge
  int            wr_cnt = 0;
  logic [AW-1:0] wa  [64];
  logic [15:0]   wd  [64];
  logic [1:0]    wbe [64];

  ti_cart_loader #(.AW(AW), .POST_HOLD(255)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .cpu_a          (cpu_a),
    .cpu_we_n       (cpu_we_n),
    .cpu_ce_n       (cpu_ce_n),
    .cpu_be_n       (cpu_be_n),
    .cpu_d_o        (cpu_d_o),
    .cpu_d_i        (cpu_d_i),
    .ram_a          (ram_a),
    .ram_we         (ram_we),
    .ram_be         (ram_be),
    .ram_d          (ram_d),
    .ram_q          (ram_q),
    .hold_reset     (hold_reset),
    .rom_mask       (rom_mask),
    .load_err       (load_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (ram_we === 1'b1) begin
      wa[wr_cnt % 64]  = ram_a;
      wd[wr_cnt % 64]  = ram_d;
      wbe[wr_cnt % 64] = ram_be;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Act 1 time unit after the falling edge, clear of the monitor and the rising edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  // Leaves one idle cycle before the strobe so ioctl_wr is never back to back
  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    tick();
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    int n;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_a = '0; cpu_we_n = 1'b1; cpu_ce_n = 1'b1;
    cpu_be_n = 2'b11; cpu_d_o = '0; ram_q = '0;
    tick(3);
    reset = 1'b0;
    tick();
    check_eq("rst_hold", hold_reset, 1);
    check_eq("rst_mask", rom_mask, 0);
    check_eq("rst_err", load_err, 0);
    check_eq("rst_we", ram_we, 0);
    check_eq("rst_be", ram_be, 0);
    check_eq("rst_a", ram_a, 0);
    check_eq("rst_d", ram_d, 0);

    // Index 1: full word at 0
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    cpu_ce_n = 1'b0; cpu_we_n = 1'b0;
    #1;
    check_eq("cpu_ignored_we", ram_we, 0);
    cpu_ce_n = 1'b1; cpu_we_n = 1'b1;
    w0 = wr_cnt;
    send_byte(25'h0, 8'h12);
    check_eq("t1_even_nowr", wr_cnt - w0, 0);
    send_byte(25'h1, 8'h34);
    check_eq("t1_we", ram_we, 1);
    check_eq("t1_a", ram_a, 0);
    check_eq("t1_d", ram_d, 16'h1234);
    check_eq("t1_be", ram_be, 2'b11);
    check_eq("t1_mask", rom_mask, 0);
    check_eq("t1_hold", hold_reset, 1);
    ioctl_download = 1'b0;
    tick(3);
    check_eq("t1_nflush", wr_cnt - w0, 1);

    // Index 3: offset 0xB000
    ioctl_index = 8'd3; ioctl_download = 1'b1;
    tick();
    send_byte(25'h10, 8'hCD);
    send_byte(25'h11, 8'hEF);
    check_eq("t2_we", ram_we, 1);
    check_eq("t2_a", ram_a, 17'h0B008);
    check_eq("t2_d", ram_d, 16'hCDEF);
    check_eq("t2_be", ram_be, 2'b11);
    check_eq("t2_mask", rom_mask, 0);
    ioctl_download = 1'b0;
    tick(3);

    // Index 2: lone even byte flushed at end of download
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    tick();
    w0 = wr_cnt;
    send_byte(25'h20, 8'hAB);
    ioctl_download = 1'b0;
    tick(3);
    check_eq("t3_cnt", wr_cnt - w0, 1);
    check_eq("t3_a", wa[w0 % 64], 17'h01010);
    check_eq("t3_dhi", wd[w0 % 64][15:8], 8'hAB);
    check_eq("t3_be", wbe[w0 % 64], 2'b10);
    check_eq("t3_mask", rom_mask, 1);

    // Index 0: odd byte for a different word than the pending one
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    w0 = wr_cnt;
    send_byte(25'h100, 8'h11);
    send_byte(25'h203, 8'h22);
    tick();
    check_eq("t5_cnt", wr_cnt - w0, 2);
    check_eq("t5_a0", wa[w0 % 64], 17'h00080);
    check_eq("t5_be0", wbe[w0 % 64], 2'b10);
    check_eq("t5_d0", wd[w0 % 64], 16'h1100);
    check_eq("t5_a1", wa[(w0 + 1) % 64], 17'h00101);
    check_eq("t5_be1", wbe[(w0 + 1) % 64], 2'b01);
    check_eq("t5_d1", wd[(w0 + 1) % 64], 16'h0022);
    ioctl_download = 1'b0;
    tick(3);

    // Index 3: wrap at top of range, then an out-of-range byte
    ioctl_index = 8'd3; ioctl_download = 1'b1;
    tick();
    w0 = wr_cnt;
    send_byte(25'h3FFFE, 8'h55);
    check_eq("t4_err0", load_err, 0);
    send_byte(25'h40000, 8'h66);
    check_eq("t4_err1", load_err, 1);
    check_eq("t4_nowr", wr_cnt - w0, 0);
    ioctl_download = 1'b0;
    // One FLUSH cycle plus 255 POST cycles of hold
    n = 0;
    tick();
    while (hold_reset && n < 1000) begin
      n++;
      tick();
    end
    check_eq("post_len", n, 256);
    check_eq("t4_cnt", wr_cnt - w0, 1);
    check_eq("t4_a", wa[w0 % 64], 17'h0AFFF);
    check_eq("t4_be", wbe[w0 % 64], 2'b10);
    check_eq("t4_dhi", wd[w0 % 64][15:8], 8'h55);
    check_eq("t4_err_sticky", load_err, 1);

    // CPU pass-through in RUN
    cpu_a = 17'h1ABCD; cpu_d_o = 16'hBEEF; cpu_be_n = 2'b10;
    cpu_ce_n = 1'b0; cpu_we_n = 1'b0; ram_q = 16'h5A5A;
    #1;
    check_eq("cpu_we", ram_we, 1);
    check_eq("cpu_be", ram_be, 2'b01);
    check_eq("cpu_a", ram_a, 17'h1ABCD);
    check_eq("cpu_d", ram_d, 16'hBEEF);
    check_eq("cpu_q", cpu_d_i, 16'h5A5A);
    cpu_ce_n = 1'b1;
    #1;
    check_eq("cpu_ce_off", ram_we, 0);
    cpu_we_n = 1'b1; cpu_be_n = 2'b11;

    // Reset with an even byte pending
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    send_byte(25'h4, 8'h77);
    w0 = wr_cnt;
    reset = 1'b1; ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    tick(4);
    check_eq("rst2_nowr", wr_cnt - w0, 0);
    check_eq("rst2_hold", hold_reset, 1);
    check_eq("rst2_err", load_err, 0);
    check_eq("rst2_we", ram_we, 0);
    check_eq("rst2_mask", rom_mask, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
